// File: rtl/uart_rx_iobus_if.sv
// IOBUS-side bundle of the UART receiver: pop/clear strobes in,
// FIFO head, occupancy, status flags and interrupt out.
// With UART_RX_PARITY_EN defined the bundle also carries PAR_ERR.
interface uart_rx_iobus_if #(
  parameter int FIFO_DEPTH = 8
) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          RD_EN;
  logic          CLR_ERR;
  logic [7:0]    RD_DATA;
  logic          RX_VALID;
  logic [CW-1:0] COUNT;
  logic          OVERRUN;
  logic          FRAME_ERR;
  logic          INTR;
`ifdef UART_RX_PARITY_EN
  logic          PAR_ERR;
`endif

  // Bus side (wrapper mux / CPU read path)
  modport master (
    output RD_EN, CLR_ERR,
    input  RD_DATA, RX_VALID, COUNT, OVERRUN, FRAME_ERR, INTR
`ifdef UART_RX_PARITY_EN
    , input PAR_ERR
`endif
  );

  // Receiver side
  modport slave (
    input  RD_EN, CLR_ERR,
    output RD_DATA, RX_VALID, COUNT, OVERRUN, FRAME_ERR, INTR
`ifdef UART_RX_PARITY_EN
    , output PAR_ERR
`endif
  );
endinterface

// File: rtl/uart_rx_iobus.sv
// UART receiver for the OTTER IOBUS read path.
// 16x oversampled 8N1 deserializer feeding a show-ahead FIFO, with sticky
// overrun/framing flags and a level interrupt that follows RX_VALID.
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing and a sticky
// PAR_ERR flag; without it the receiver is plain 8N1.
module uart_rx_iobus #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           RX,
  uart_rx_iobus_if.slave bus
);

  // Rounded clocks per 16x tick
  localparam int DIV   = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  // Synchronizer
  logic rx_meta_q, rx_sync_q;

  // Tick generator
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;
  logic             restart;

  // Receive FSM
  state_e     state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       stop_bad_q, stop_bad_d;
  logic       push_q, push_d;
  logic       frame_set;
`ifdef UART_RX_PARITY_EN
  logic       par_bad_q, par_bad_d;
  logic       par_set;
  logic       par_err_q;
`endif

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          empty, full, pop, wr_en, ovr_set;

  // Sticky flags
  logic overrun_q, frame_err_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign tick = (div_cnt_q == DIV_W'(DIV - 1));

  // Free-running 16x tick divider, realigned to each detected start edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_q <= '0;
    end else if (restart || tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  // FSM control registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_bad_q <= 1'b0;
      push_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_bad_q <= stop_bad_d;
      push_q     <= push_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
`endif
    end
  end

  // Deserializer shift register (data only, no reset)
  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
  end

  // Next-state logic: mid-bit sampling, LSB-first shifting, stop-bit check
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_bad_d = stop_bad_q;
    push_d     = 1'b0;
    restart    = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    par_set    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          restart    = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            // Mid start bit: a high line here was only a glitch
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = '0;
            shift_d    = {rx_sync_q, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            // Even parity: data bits plus parity bit must XOR to zero
            tick_cnt_d = '0;
            par_bad_d  = ^{shift_q, rx_sync_q};
            par_set    = par_bad_d;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
`endif
      S_STOP: begin
        if (stop_bad_q) begin
          // Broken frame: hold off until the line returns to idle
          if (rx_sync_q) begin
            stop_bad_d = 1'b0;
            state_d    = S_IDLE;
          end
        end else if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = '0;
            if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
              push_d = !par_bad_q;
`else
              push_d = 1'b1;
`endif
              state_d = S_IDLE;
            end else begin
              frame_set  = 1'b1;
              stop_bad_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = bus.RD_EN && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en   = push_q && (!full || pop);
  assign ovr_set = push_q && full && !pop;

  // Occupancy follows net push/pop
  always_comb begin
    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !wr_en) begin
      count_d = count_q - CW'(1);
    end
  end

  // FIFO pointers and occupancy; pointers wrap at the power-of-two depth
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage (data only, no reset)
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  // Sticky error flags; a set event beats a simultaneous clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      overrun_q   <= ovr_set   ? 1'b1 : (bus.CLR_ERR ? 1'b0 : overrun_q);
      frame_err_q <= frame_set ? 1'b1 : (bus.CLR_ERR ? 1'b0 : frame_err_q);
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_set   ? 1'b1 : (bus.CLR_ERR ? 1'b0 : par_err_q);
`endif
    end
  end

  assign bus.RD_DATA   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.RX_VALID  = !empty;
  assign bus.INTR      = !empty;
  assign bus.COUNT     = count_q;
  assign bus.OVERRUN   = overrun_q;
  assign bus.FRAME_ERR = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.PAR_ERR   = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_iobus.sv
// Bench for uart_rx_iobus: table of single frames plus hand-written
// sequences for glitch, mid-frame reset, overrun, same-cycle push/pop and
// set-beats-clear. Expected bytes flow through a scoreboard queue.
module tb_uart_rx_iobus;
  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 781250;      // 4 clocks per tick, 64 per bit
  localparam int DEPTH    = 8;
  localparam int DIV      = 4;
  localparam int BIT      = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int NTICK = 168;
`else
  localparam int NTICK = 152;
`endif
  // Edges after the one preceding the start bit: 2 sync + 1 detect + ticks
  localparam int PUSH_EDGE = 3 + DIV * NTICK;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  logic RX    = 1'b1;

  uart_rx_iobus_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_iobus #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .RX   (RX),
    .bus  (bus)
  );

  always #10 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_ferr;
    logic       exp_push;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    RX = v;
    tick(BIT);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    tick(1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`else
    if (par_flip) RX = 1'b1;
`endif
    drive_bit(stop_bit);
    RX = 1'b1;
    tick(8);
  endtask

  task automatic pulse_rd();
    bus.RD_EN = 1'b1;
    tick(1);
    bus.RD_EN = 1'b0;
    tick(1);
  endtask

  task automatic pulse_clr();
    bus.CLR_ERR = 1'b1;
    tick(1);
    bus.CLR_ERR = 1'b0;
    tick(1);
  endtask

  task automatic pop_check(input string name);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, RD_DATA=%0h", name, bus.RD_DATA);
    end else begin
      exp = sb.pop_front();
      check(name, bus.RD_DATA, exp);
    end
    pulse_rd();
  endtask

  // Send a good frame and pop exactly in the cycle its byte is pushed
  task automatic send_pop(input logic [7:0] b);
    logic       had;
    logic [7:0] head;
    had  = (sb.size() != 0);
    head = 8'h00;
    if (had) head = sb.pop_front();
    sb.push_back(b);
    fork
      send_frame(b, 1'b1, 1'b0);
      begin
        tick(1);
        tick(PUSH_EDGE);
        check("pop_head", bus.RD_DATA, head);
        bus.RD_EN = 1'b1;
        tick(1);
        bus.RD_EN = 1'b0;
      end
    join
  endtask

  // Send a frame with CLR_ERR sampled at the given edge of the frame
  task automatic send_clr(input logic [7:0] b, input logic stop_bit, input int at);
    fork
      send_frame(b, stop_bit, 1'b0);
      begin
        tick(1);
        tick(at);
        bus.CLR_ERR = 1'b1;
        tick(1);
        bus.CLR_ERR = 1'b0;
      end
    join
  endtask

  initial begin
    repeat (90000) @(posedge CLK);
    $display("FAIL watchdog: run exceeded 90000 cycles, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b0, 1'b1};

    bus.RD_EN   = 1'b0;
    bus.CLR_ERR = 1'b0;
    RST_N = 1'b0;
    RX    = 1'b1;
    tick(5);
    RST_N = 1'b1;
    tick(2);
    check("rst_rd_data", bus.RD_DATA, 0);
    check("rst_valid", bus.RX_VALID, 0);
    check("rst_count", bus.COUNT, 0);
    check("rst_overrun", bus.OVERRUN, 0);
    check("rst_frame_err", bus.FRAME_ERR, 0);
    check("rst_intr", bus.INTR, 0);
`ifdef UART_RX_PARITY_EN
    check("rst_par_err", bus.PAR_ERR, 0);
`endif

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].exp_push) sb.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      check("vec_frame_err", bus.FRAME_ERR, vecs[i].exp_ferr);
      check("vec_count", bus.COUNT, vecs[i].exp_push);
      check("vec_valid", bus.RX_VALID, vecs[i].exp_push);
      check("vec_intr", bus.INTR, vecs[i].exp_push);
      if (vecs[i].exp_push) begin
        pop_check("vec_data");
        check("vec_count_after_pop", bus.COUNT, 0);
        check("vec_rd_data_empty", bus.RD_DATA, 0);
      end
      if (vecs[i].exp_ferr) begin
        pulse_clr();
        check("vec_frame_err_clr", bus.FRAME_ERR, 0);
      end
    end

    // Pop on empty FIFO is ignored
    pulse_rd();
    check("empty_pop_count", bus.COUNT, 0);
    check("empty_pop_rd_data", bus.RD_DATA, 0);

    // Start glitch shorter than half a bit
    tick(1);
    RX = 1'b0;
    tick(20);
    RX = 1'b1;
    tick(BIT);
    check("glitch_count", bus.COUNT, 0);
    check("glitch_frame_err", bus.FRAME_ERR, 0);
    check("glitch_overrun", bus.OVERRUN, 0);
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    check("glitch_next_count", bus.COUNT, 1);
    pop_check("glitch_next_data");

    // Reset in the middle of a frame drops the partial byte
    tick(1);
    RX = 1'b0;
    tick(BIT);
    RX = 1'b1;
    tick(BIT * 2);
    RST_N = 1'b0;
    tick(3);
    RST_N = 1'b1;
    tick(BIT * 12);
    check("midrst_count", bus.COUNT, 0);
    check("midrst_frame_err", bus.FRAME_ERR, 0);

    // Overrun: nine bytes into eight entries
    for (int v = 1; v <= 9; v++) begin
      if (sb.size() < DEPTH) sb.push_back(8'(v));
      send_frame(8'(v), 1'b1, 1'b0);
    end
    check("ovr_count", bus.COUNT, DEPTH);
    check("ovr_flag", bus.OVERRUN, 1);
    for (int k = 0; k < DEPTH; k++) pop_check("ovr_data");
    check("ovr_drained", bus.COUNT, 0);
    check("ovr_flag_kept", bus.OVERRUN, 1);
    pulse_clr();
    check("ovr_clr", bus.OVERRUN, 0);

    // Full FIFO with pop in the push cycle
    for (int v = 0; v < DEPTH; v++) begin
      sb.push_back(8'h10 + 8'(v));
      send_frame(8'h10 + 8'(v), 1'b1, 1'b0);
    end
    check("full_count", bus.COUNT, DEPTH);
    send_pop(8'h7E);
    check("fullpop_overrun", bus.OVERRUN, 0);
    check("fullpop_count", bus.COUNT, DEPTH);
    for (int k = 0; k < DEPTH; k++) pop_check("fullpop_data");

    // Empty FIFO with pop in the push cycle: pop ignored, push kept
    send_pop(8'h5A);
    check("emptypop_count", bus.COUNT, 1);
    pop_check("emptypop_data");

    // Framing error coinciding with CLR_ERR: set wins
    send_clr(8'h33, 1'b0, PUSH_EDGE - 1);
    check("setwins_frame_err", bus.FRAME_ERR, 1);
    check("setwins_count", bus.COUNT, 0);
    pulse_clr();
    check("setwins_cleared", bus.FRAME_ERR, 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_err_set", bus.PAR_ERR, 1);
    check("par_count", bus.COUNT, 0);
    check("par_frame_err", bus.FRAME_ERR, 0);
    pulse_clr();
    check("par_err_clr", bus.PAR_ERR, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
